// File: rtl/vae_pkg.sv
// Shared defaults, FSM encoding and saturation limits for the accumulator scheduler.
package vae_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int DATA_W_DEF  = 16;
   localparam int LEN_W_DEF   = 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_GRANT  = 2'd1;
   localparam logic [1:0] ST_ACCUM  = 2'd2;
   localparam logic [1:0] ST_OUTPUT = 2'd3;

   localparam logic [DATA_W_DEF-1:0] SAT_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
   localparam logic [DATA_W_DEF-1:0] SAT_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

endpackage

// File: rtl/accum_scheduler_if.sv
// Requester / result bus of the accumulator scheduler.
interface accum_scheduler_if #(
   parameter int NUM_REQ = vae_pkg::NUM_REQ_DEF,
   parameter int DATA_W  = vae_pkg::DATA_W_DEF,
   parameter int LEN_W   = vae_pkg::LEN_W_DEF
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        in_valid;
   logic [NUM_REQ*DATA_W-1:0] in_data;
   logic [NUM_REQ*LEN_W-1:0]  burst_len;
   logic [NUM_REQ-1:0]        grant;
   logic [NUM_REQ-1:0]        in_ready;
   logic                      out_valid;
   logic [DATA_W-1:0]         out_data;
   logic [ID_W-1:0]           out_id;
   logic                      out_ready;
   logic                      abort;

   modport master (
      output req, in_valid, in_data, burst_len, out_ready,
      input  grant, in_ready, out_valid, out_data, out_id, abort
   );

   modport slave (
      input  req, in_valid, in_data, burst_len, out_ready,
      output grant, in_ready, out_valid, out_data, out_id, abort
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requesting index at or above ptr, wrapping around.
module rr_arbiter #(
   parameter int NUM_REQ = vae_pkg::NUM_REQ_DEF,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] winner
);

   int   idx;
   logic found;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/accum_scheduler.sv
// Shared saturating accumulator: one requester at a time owns it for a burst,
// result is held until downstream accepts, owner losing req drops the burst.
module accum_scheduler import vae_pkg::*; #(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int LEN_W   = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   accum_scheduler_if.slave  bus
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [DATA_W-1:0] LIM_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] LIM_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   logic [1:0]         state_q, state_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [ID_W-1:0]    owner_q, owner_d;
   logic [LEN_W-1:0]   count_q, count_d;
   logic [DATA_W-1:0]  sum_q, sum_d;
   logic               abort_q, abort_d;

   logic [NUM_REQ-1:0] win_oh, own_oh;
   logic [ID_W-1:0]    win_idx, next_ptr;
   logic [DATA_W-1:0]  own_data, sat_sum;
   logic [LEN_W-1:0]   own_len;
   logic [DATA_W:0]    sum_ext;
   logic               own_req, own_valid;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .req    (bus.req),
      .ptr    (ptr_q),
      .winner (win_oh)
   );

   always_comb begin
      own_oh   = '0;
      own_data = '0;
      own_len  = '0;
      win_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == ID_W'(i)) begin
            own_oh[i] = 1'b1;
            own_data  = bus.in_data[i*DATA_W +: DATA_W];
            own_len   = bus.burst_len[i*LEN_W +: LEN_W];
         end
         if (win_oh[i]) win_idx = ID_W'(i);
      end
   end

   assign own_req   = |(bus.req & own_oh);
   assign own_valid = |(bus.in_valid & own_oh);
   assign next_ptr  = (owner_q == ID_W'(NUM_REQ-1)) ? '0 : owner_q + ID_W'(1);

   // One guard bit: the two top bits disagree exactly when the add overflowed.
   assign sum_ext = {sum_q[DATA_W-1], sum_q} + {own_data[DATA_W-1], own_data};
   assign sat_sum = (sum_ext[DATA_W] != sum_ext[DATA_W-1]) ?
                    (sum_ext[DATA_W] ? LIM_MIN : LIM_MAX) : sum_ext[DATA_W-1:0];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      count_d = count_q;
      sum_d   = sum_q;
      abort_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|bus.req) begin
               owner_d = win_idx;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            sum_d   = '0;
            count_d = own_len;
            if (!own_req) begin
               abort_d = 1'b1;
               ptr_d   = next_ptr;
               state_d = ST_IDLE;
            end else if (own_len == '0) begin
               state_d = ST_OUTPUT;
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (!own_req) begin
               abort_d = 1'b1;
               ptr_d   = next_ptr;
               state_d = ST_IDLE;
            end else if (own_valid) begin
               sum_d   = sat_sum;
               count_d = count_q - LEN_W'(1);
               if (count_q == LEN_W'(1)) state_d = ST_OUTPUT;
            end
         end
         ST_OUTPUT: begin
            if (bus.out_ready) begin
               ptr_d   = next_ptr;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         count_q <= '0;
         sum_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         count_q <= count_d;
         sum_q   <= sum_d;
         abort_q <= abort_d;
      end
   end

   assign bus.grant     = (state_q == ST_GRANT || state_q == ST_ACCUM) ? own_oh : '0;
   assign bus.in_ready  = (state_q == ST_ACCUM) ? own_oh : '0;
   assign bus.out_valid = (state_q == ST_OUTPUT);
   assign bus.out_data  = sum_q;
   assign bus.out_id    = owner_q;
   assign bus.abort     = abort_q;

endmodule

// File: tb/tb_accum_scheduler.sv
// Randomized and directed checks of accum_scheduler against a burst-level model.
module tb_accum_scheduler;

   localparam int NR = 4;
   localparam int DW = 16;
   localparam int LW = 8;
   localparam longint SMAX = (longint'(1) << (DW-1)) - 1;
   localparam longint SMIN = -(longint'(1) << (DW-1));

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   accum_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW), .LEN_W(LW)) bus ();

   accum_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .LEN_W(LW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int mptr   = 0;
   int samp [NR][16];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req       = '0;
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.burst_len = '0;
      bus.out_ready = 1'b0;
   endtask

   task automatic set_len(input int who, input int len);
      bus.burst_len[who*LW +: LW] = LW'(len);
   endtask

   task automatic set_data(input int who, input int v);
      bus.in_data[who*DW +: DW] = DW'(v);
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      clear_inputs();
      step();
      step();
      rst_n = 1'b1;
      step();
      mptr = 0;
   endtask

   // Reference: round-robin search from the pointer, and a clamped running sum.
   function automatic int rr_pick(input logic [NR-1:0] mask, input int ptr);
      for (int k = 0; k < NR; k++)
         if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
      return -1;
   endfunction

   function automatic logic [DW-1:0] model_sum(input int who, input int len);
      longint s = 0;
      for (int n = 0; n < len; n++) begin
         s = s + samp[who][n];
         if (s > SMAX) s = SMAX;
         if (s < SMIN) s = SMIN;
      end
      return DW'(s);
   endfunction

   // Every requester in mask streams its own samples; only the owner may drain.
   task automatic run_round(input logic [NR-1:0] mask, input int lens[NR], input int gap,
                            output logic [NR-1:0] first_grant, output logic [DW-1:0] got_data,
                            output int got_id, output int accepted, output bit ok);
      int idx [NR];
      logic [NR-1:0] acc;
      bit done;
      first_grant = '0;
      got_data    = '0;
      got_id      = -1;
      accepted    = 0;
      ok          = 1'b0;
      bus.req     = mask;
      for (int i = 0; i < NR; i++) begin
         idx[i] = 0;
         set_len(i, lens[i]);
      end
      for (int cyc = 0; cyc < 300; cyc++) begin
         for (int i = 0; i < NR; i++) begin
            if (idx[i] < lens[i]) set_data(i, samp[i][idx[i]]);
            bus.in_valid[i] = mask[i] && (idx[i] < lens[i]) && ($urandom_range(0, 99) >= gap);
         end
         acc  = bus.in_ready & bus.in_valid;
         done = bus.out_valid;
         if (done) begin
            got_data      = bus.out_data;
            got_id        = int'(bus.out_id);
            bus.out_ready = 1'b1;
         end
         step();
         for (int i = 0; i < NR; i++)
            if (acc[i]) begin
               idx[i]++;
               accepted++;
            end
         if (first_grant == '0 && bus.grant != '0) first_grant = bus.grant;
         if (done) begin
            clear_inputs();
            ok = 1'b1;
            break;
         end
      end
      if (!ok) clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      step();
      step();
      checks++; if (bus.grant !== '0) begin errors++; $display("FAIL reset_grant: got %b expected 0", bus.grant); end
      checks++; if (bus.in_ready !== '0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
      checks++; if (bus.out_id !== '0) begin errors++; $display("FAIL reset_out_id: got %0d expected 0", bus.out_id); end
      checks++; if (bus.abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b expected 0", bus.abort); end
      rst_n = 1'b1;
      step();
      mptr = 0;
   endtask

   task automatic test_basic();
      clear_inputs();
      bus.req = 4'b0001;
      set_len(0, 3);
      step();
      checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL basic_grant: got %b expected 0001", bus.grant); end
      checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL basic_ready_in_grant: got %b expected 0000", bus.in_ready); end
      bus.in_valid[0] = 1'b1;
      set_data(0, 1);
      step();
      checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL basic_ready_in_accum: got %b expected 0001", bus.in_ready); end
      step();
      set_data(0, 2);
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", bus.out_valid); end
      set_data(0, 3);
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b expected 1", bus.out_valid); end
      checks++; if (bus.out_data !== 16'd6) begin errors++; $display("FAIL basic_out_data: got %0d expected 6", bus.out_data); end
      checks++; if (bus.out_id !== 2'd0) begin errors++; $display("FAIL basic_out_id: got %0d expected 0", bus.out_id); end
      checks++; if (bus.grant !== '0) begin errors++; $display("FAIL basic_grant_in_output: got %b expected 0", bus.grant); end
      bus.in_valid  = '0;
      bus.out_ready = 1'b1;
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_release: got %b expected 0", bus.out_valid); end
      clear_inputs();
      mptr = 1;
   endtask

   task automatic test_round_robin();
      int ids [5];
      int at  [5];
      int got = 0;
      int exp_ids [5] = '{0, 1, 2, 3, 0};
      reset_dut();
      bus.req       = '1;
      bus.in_valid  = '1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < NR; i++) begin
         set_len(i, 1);
         set_data(i, 10 * (i + 1));
      end
      for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
         step();
         if (bus.out_valid) begin
            ids[got] = int'(bus.out_id);
            at[got]  = cyc;
            got++;
         end
      end
      checks++; if (got != 5) begin errors++; $display("FAIL rr_timeout: got %0d results expected 5", got); end
      for (int n = 0; n < got; n++) begin
         checks++; if (ids[n] != exp_ids[n]) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", n, ids[n], exp_ids[n]); end
         if (n > 0) begin
            checks++; if (at[n] - at[n-1] != 4) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d expected 4", n, at[n] - at[n-1]); end
         end
      end
      bus.req      = '0;
      bus.in_valid = '0;
      step();
      clear_inputs();
      mptr = 1;
   endtask

   task automatic test_saturation();
      int lens [NR] = '{0, 0, 4, 0};
      logic [NR-1:0] fg;
      logic [DW-1:0] d;
      int id, accn;
      bit ok;
      for (int n = 0; n < 4; n++) samp[2][n] = 16384;
      run_round(4'b0100, lens, 0, fg, d, id, accn, ok);
      checks++; if (!ok) begin errors++; $display("FAIL sat_pos_timeout: got no result expected one"); end
      checks++; if (d !== 16'h7FFF) begin errors++; $display("FAIL sat_pos: got %h expected 7fff", d); end
      checks++; if (accn != 4) begin errors++; $display("FAIL sat_pos_accepts: got %0d expected 4", accn); end
      for (int n = 0; n < 4; n++) samp[2][n] = -16384;
      run_round(4'b0100, lens, 0, fg, d, id, accn, ok);
      checks++; if (d !== 16'h8000) begin errors++; $display("FAIL sat_neg: got %h expected 8000", d); end
      checks++; if (id != 2) begin errors++; $display("FAIL sat_neg_id: got %0d expected 2", id); end
      mptr = 3;
   endtask

   task automatic test_abort();
      int acc_n = 0;
      bit a;
      bit seen_valid = 1'b0;
      int exp_w;
      clear_inputs();
      bus.req = 4'b0010;
      set_len(1, 5);
      bus.in_valid[1] = 1'b1;
      for (int cyc = 0; cyc < 20 && acc_n < 2; cyc++) begin
         set_data(1, 100 + acc_n);
         a = bus.in_ready[1] & bus.in_valid[1];
         step();
         if (a) acc_n++;
      end
      checks++; if (acc_n != 2) begin errors++; $display("FAIL abort_setup: got %0d accepts expected 2", acc_n); end
      bus.req      = '0;
      bus.in_valid = '0;
      step();
      checks++; if (bus.abort !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b expected 1", bus.abort); end
      checks++; if (bus.grant !== '0) begin errors++; $display("FAIL abort_grant: got %b expected 0", bus.grant); end
      step();
      checks++; if (bus.abort !== 1'b0) begin errors++; $display("FAIL abort_width: got %b expected 0", bus.abort); end
      for (int cyc = 0; cyc < 5; cyc++) begin
         if (bus.out_valid) seen_valid = 1'b1;
         step();
      end
      checks++; if (seen_valid) begin errors++; $display("FAIL abort_no_valid: got out_valid 1 expected 0"); end
      exp_w = rr_pick(4'b1111, 2);
      bus.req = '1;
      for (int i = 0; i < NR; i++) set_len(i, 1);
      step();
      checks++; if (bus.grant !== NR'(1 << exp_w)) begin errors++; $display("FAIL abort_next_grant: got %b expected %b", bus.grant, NR'(1 << exp_w)); end
      bus.req = '0;
      step();
      checks++; if (bus.abort !== 1'b1) begin errors++; $display("FAIL abort_in_grant: got %b expected 1", bus.abort); end
      step();
      clear_inputs();
      mptr = (exp_w + 1) % NR;
   endtask

   task automatic test_backpressure();
      bit a, ok = 1'b0;
      int acc_n = 0;
      int exp_w;
      clear_inputs();
      samp[0][0] = 7;
      samp[0][1] = -3;
      bus.req = 4'b0001;
      set_len(0, 2);
      set_len(3, 1);
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (bus.out_valid) begin ok = 1'b1; break; end
         bus.in_valid[0] = (acc_n < 2);
         if (acc_n < 2) set_data(0, samp[0][acc_n]);
         a = bus.in_ready[0] & bus.in_valid[0];
         step();
         if (a) acc_n++;
      end
      checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got no out_valid expected 1"); end
      bus.in_valid = '0;
      bus.req      = 4'b1001;
      for (int cyc = 0; cyc < 10; cyc++) begin
         step();
         checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== model_sum(0, 2) || bus.out_id !== 2'd0 || bus.grant !== '0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got v=%b d=%h id=%0d g=%b expected v=1 d=%h id=0 g=0",
                     cyc, bus.out_valid, bus.out_data, bus.out_id, bus.grant, model_sum(0, 2));
         end
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      bus.req       = 4'b1000;
      checks++; if (bus.out_valid !== 1'b0 || bus.grant !== '0) begin errors++; $display("FAIL bp_bubble: got v=%b g=%b expected v=0 g=0", bus.out_valid, bus.grant); end
      exp_w = rr_pick(4'b1000, 1);
      step();
      checks++; if (bus.grant !== NR'(1 << exp_w)) begin errors++; $display("FAIL bp_next_grant: got %b expected %b", bus.grant, NR'(1 << exp_w)); end
      bus.req = '0;
      step();
      step();
      clear_inputs();
      mptr = (exp_w + 1) % NR;
   endtask

   task automatic test_async_reset();
      int acc_n = 0;
      bit a;
      int lens [NR] = '{0, 0, 3, 0};
      logic [NR-1:0] fg;
      logic [DW-1:0] d;
      int id, accn;
      bit ok;
      clear_inputs();
      bus.req = 4'b0100;
      set_len(2, 6);
      set_data(2, 500);
      bus.in_valid[2] = 1'b1;
      for (int cyc = 0; cyc < 20 && acc_n < 2; cyc++) begin
         a = bus.in_ready[2] & bus.in_valid[2];
         step();
         if (a) acc_n++;
      end
      #3 rst_n = 1'b0;
      #1;
      checks++; if (bus.grant !== '0 || bus.in_ready !== '0) begin errors++; $display("FAIL areset_grant_ready: got g=%b r=%b expected 0", bus.grant, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0 || bus.abort !== 1'b0) begin errors++; $display("FAIL areset_valid_abort: got v=%b a=%b expected 0", bus.out_valid, bus.abort); end
      checks++; if (bus.out_data !== '0 || bus.out_id !== '0) begin errors++; $display("FAIL areset_data_id: got d=%h id=%0d expected 0", bus.out_data, bus.out_id); end
      clear_inputs();
      @(negedge clk);
      #2 rst_n = 1'b1;
      step();
      mptr = 0;
      for (int n = 0; n < 3; n++) samp[2][n] = 9;
      run_round(4'b0110, lens, 0, fg, d, id, accn, ok);
      checks++; if (fg !== 4'b0010) begin errors++; $display("FAIL areset_first_grant: got %b expected 0010", fg); end
      checks++; if (!ok || d !== '0 || id != 1) begin errors++; $display("FAIL areset_len0: got ok=%b d=%h id=%0d expected ok=1 d=0 id=1", ok, d, id); end
      checks++; if (accn != 0) begin errors++; $display("FAIL areset_len0_accepts: got %0d expected 0", accn); end
      mptr = 2;
   endtask

   task automatic test_random();
      int lens [NR];
      logic [NR-1:0] mask, fg;
      logic [DW-1:0] d;
      int id, accn, w, gap;
      bit ok;
      for (int r = 0; r < 24; r++) begin
         mask = NR'($urandom_range(1, (1 << NR) - 1));
         gap  = $urandom_range(0, 40);
         for (int i = 0; i < NR; i++) begin
            lens[i] = $urandom_range(0, 8);
            for (int n = 0; n < 16; n++) begin
               if ($urandom_range(0, 1) == 1) samp[i][n] = $urandom_range(0, 65535) - 32768;
               else samp[i][n] = ($urandom_range(0, 1) == 1) ? $urandom_range(20000, 32767)
                                                             : -$urandom_range(20000, 32768);
            end
         end
         w = rr_pick(mask, mptr);
         run_round(mask, lens, gap, fg, d, id, accn, ok);
         checks++; if (!ok) begin errors++; $display("FAIL rand_timeout[%0d]: got no result expected one", r); end
         checks++; if (fg !== NR'(1 << w)) begin errors++; $display("FAIL rand_grant[%0d]: got %b expected %b", r, fg, NR'(1 << w)); end
         checks++; if (id != w) begin errors++; $display("FAIL rand_id[%0d]: got %0d expected %0d", r, id, w); end
         checks++; if (d !== model_sum(w, lens[w])) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", r, d, model_sum(w, lens[w])); end
         checks++; if (accn != lens[w]) begin errors++; $display("FAIL rand_accepts[%0d]: got %0d expected %0d", r, accn, lens[w]); end
         mptr = (w + 1) % NR;
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_basic();
      test_round_robin();
      test_saturation();
      test_abort();
      test_backpressure();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/accum_scheduler.md
ACCUM_SCHEDULER -- requirements
Module: accum_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the accumulator.
REQ-002 Parameter DATA_W, default 16, signed fixed-point sample/result width.
REQ-003 Parameter LEN_W, default 8, width of the burst-length field.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NUM_REQ  per-requester level request; held until burst ends.
REQ-007 in_valid  input  NUM_REQ  per-requester sample valid.
REQ-008 in_data  input  NUM_REQ*DATA_W  flattened samples; requester i at bits [i*DATA_W +: DATA_W].
REQ-009 burst_len  input  NUM_REQ*LEN_W  flattened per-requester sample count.
REQ-010 grant  output  NUM_REQ  one-hot owner of the accumulator, or all-zero.
REQ-011 in_ready  output  NUM_REQ  sample accept; equals grant while in ACCUM, else 0.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_data  output  DATA_W  saturated accumulated sum.
REQ-014 out_id  output  clog2(NUM_REQ)  index of the requester that owns out_data.
REQ-015 out_ready  input  1  downstream result accept.
REQ-016 abort  output  1  one-cycle pulse when a burst is dropped.

Function
REQ-017 FSM states IDLE, GRANT, ACCUM, OUTPUT; only these are reachable.
REQ-018 IDLE: if any req bit is set, choose round-robin winner from pointer upward, go to GRANT next cycle.
REQ-019 GRANT (1 cycle): assert grant one-hot, latch winner's burst_len into count, clear sum to 0; go ACCUM.
REQ-020 A sample is accepted when state is ACCUM and in_valid and in_ready of the owner are both 1; count decrements by one per accepted sample.
REQ-021 Accumulation is signed, computed DATA_W+1 wide, clamped to +2^(DATA_W-1)-1 / -2^(DATA_W-1) on every add (0x7FFF / 0x8000 at default).
REQ-022 ACCUM -> OUTPUT in the cycle after the last sample (count reaches 0) is accepted; burst_len 0 goes GRANT -> OUTPUT with out_data 0.
REQ-023 OUTPUT: out_valid=1, out_data and out_id stable until out_ready=1; grant and in_ready are 0.
REQ-024 On out_valid and out_ready both 1, go IDLE; pointer becomes owner+1 modulo NUM_REQ.
REQ-025 If the owner's req falls during GRANT or ACCUM, drop the burst: pulse abort 1 cycle, no out_valid, pointer advances to owner+1, go IDLE.
REQ-026 New requests arriving in OUTPUT wait; arbitration only in IDLE (one-cycle bubble between bursts is required).
REQ-027 Non-owner in_valid is ignored; samples never mix between requesters.
REQ-028 Throughput: one sample per clock in ACCUM when in_valid is held high.

Reset
REQ-029 rst_n low, asynchronously: state IDLE, grant 0, in_ready 0, out_valid 0, out_data 0, out_id 0, abort 0, pointer 0, sum 0, count 0.
REQ-030 Reset mid-burst discards the partial sum; first post-reset grant goes to lowest requesting index.

Structure
REQ-031 The shared package vae_pkg holds DATA_W, NUM_REQ, LEN_W defaults, the FSM state encoding, and the saturation limits.
REQ-032 Round-robin selection is a sub-module rr_arbiter (inputs req, pointer; outputs one-hot winner); the FSM, counter and saturating adder stay in accum_scheduler.

Verification
REQ-033 req=0001, len=3, samples 1,2,3 -> grant 0001 one cycle after req, out_data=6, out_id=0, out_valid the cycle after the third accept.
REQ-034 req=1111 held, each len=1, out_ready=1 -> out_id sequence 0,1,2,3,0.
REQ-035 len=4, samples 0x4000 x4 -> out_data=0x7FFF; samples 0xC000 x4 -> 0x8000.
REQ-036 Owner drops req after 2 of 5 samples -> abort 1-cycle pulse, no out_valid, next grant to owner+1.
REQ-037 out_ready held 0 for 10 cycles -> out_valid, out_data, out_id stable; new req not granted until 1 cycle after out_ready.
REQ-038 rst_n pulsed low mid-ACCUM (asynchronous to clk) -> all outputs 0 immediately; burst_len=0 after reset -> out_data=0 with no sample accepted.
